issue_queue: RTL and testbench
==============================

# issue_queue

Dual-issue instruction queue sitting between the decoder and the launch-select stage. It buffers up to DEPTH decoded instructions (pc, npc, decodeout), presents the two oldest eligible entries as slot 1 / slot 2 with receive flags, and retires entries according to the 4-bit launch_flag returned by launch-select. It supports launching slot 2 ahead of slot 1 (one-deep skip) and a synchronous flush for redirects.

## Interface
- DEPTH, 8, entry count; power of two, ≥4
- PC_W, 32, width of pc/npc
- DC_W, 67, width of decodeout bundle
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries and skip state
- in_valid1  in  1  push entry A (older)
- in_pc1, in_npc1  in  PC_W  entry A pc/npc
- in_decodeout1  in  DC_W  entry A decode bundle
- in_valid2  in  1  push entry B (younger); only legal with in_valid1
- in_pc2, in_npc2, in_decodeout2  in  PC_W/PC_W/DC_W  entry B
- in_ready  out  1  count ≤ DEPTH-2
- out1_pc, out1_npc, out1_decodeout  out  PC_W/PC_W/DC_W  slot 1 payload
- receive_flag1  out  1  slot 1 valid
- out2_pc, out2_npc, out2_decodeout  out  PC_W/PC_W/DC_W  slot 2 payload
- receive_flag2  out  1  slot 2 valid
- launch_flag  in  4  [3] slot1→exec1, [2] slot1→exec2, [1] slot2→exec1, [0] slot2→exec2
- count  out  clog2(DEPTH)+1  occupied entries (incl. skipped-ahead entry)

## Operation
- State: storage array, head/tail pointers (clog2(DEPTH) bits, wrap modulo DEPTH), count, skip bit (entry head+1 already launched).
- Slot 1 = entry[head], receive_flag1 = count≥1.
- Slot 2 = entry[head+1] if skip=0, valid when count≥2; if skip=1, receive_flag2 = 0 and payload = entry[head+2] (don't-care).
- l1 = (launch_flag[3]|launch_flag[2]) & receive_flag1; l2 = (launch_flag[1]|launch_flag[0]) & receive_flag2. Launch bits on an invalid slot are ignored.
- Retire per cycle: skip=0: l1&l2 → head+=2; l1 only → head+=1; l2 only → head unchanged, skip←1. skip=1: l1 → head+=2, skip←0.
- Push: in_valid1 writes tail, in_valid2 writes tail+1; tail advances by number pushed. Pushes while in_ready=0 are dropped (protocol error, no state change from the push). in_valid2 without in_valid1 ignored.
- count_next = count + pushed − retired, retired counting the skipped entry when head moves past it.
- flush: head, tail, count, skip ← 0 next cycle; same-cycle push and launch ignored. rst identical, plus payload outputs read 0 after reset (storage cleared).

## Timing
- Reset values: receive_flag1/2 = 0, count = 0, in_ready = 1, all payload outputs 0.
- Slot outputs are combinational from registered state only (no input-to-output path); launch_flag must arrive same cycle and affects state at next edge.
- Push-to-visible latency 1 cycle: entry pushed into empty queue appears as slot 1 in the next cycle.
- in_ready derived from current count only (pops in the same cycle not credited).
- Simultaneous push and retire in the same cycle both take effect; full (count=DEPTH) with 2 launches and 2 pushes is impossible since in_ready=0 at count>DEPTH-2.
- Pointer wrap at DEPTH-1→0 needs no special case.

## Structure
- Shared header (def.vh): PC_W, DC_W, launch_flag bit indices (LF_S1E1=3, LF_S1E2=2, LF_S2E1=1, LF_S2E2=0).
- Sub-module iq_store: DEPTH×(2·PC_W+DC_W) register array, two write ports, three combinational read ports (head, head+1, head+2), synchronous clear.
- Control (pointers, count, skip, flags) in issue_queue top.

## Test plan
- Reset then idle: receive_flag1/2=0, count=0, in_ready=1, payloads 0.
- Push A(pc=0x100),B(pc=0x104) cycle 0; cycle 1 slot1.pc=0x100, slot2.pc=0x104, both flags 1; launch_flag=4'b1001 → cycle 2 count=0.
- Push 4 entries; launch_flag=4'b0010 (slot2 only) → next cycle skip=1, slot1 still pc0, receive_flag2=0, count=4; launch_flag=4'b1000 → slot1=pc2, count=2.
- Fill to count=7: in_ready=0; assert push of 2 → dropped, count stays 7; launch 2 → count 5, in_ready 1.
- Push/launch across wrap (DEPTH=8, 20 entries streamed 2/cycle with 2 launches/cycle): pc order preserved, count stable.
- flush with simultaneous push and launch_flag=4'b1111 at count=5 → next cycle count=0, flags 0, skip cleared.

Source files
------------

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the dual-issue instruction queue.
package issue_queue_pkg;

    // Default payload widths.
    localparam int unsigned IQ_PC_W = 32;
    localparam int unsigned IQ_DC_W = 67;

    // Bit positions inside launch_flag.
    localparam int unsigned LF_S1E1 = 3;
    localparam int unsigned LF_S1E2 = 2;
    localparam int unsigned LF_S2E1 = 1;
    localparam int unsigned LF_S2E2 = 0;

    // Skip state: whether the entry at head+1 has already launched ahead of head.
    typedef enum logic {
        SK_NONE  = 1'b0,
        SK_AHEAD = 1'b1
    } skip_e;

endpackage

// File: rtl/issue_queue_store.sv
// Entry storage for the issue queue: two write ports, three combinational reads.
module iq_store #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned EW    = 131
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     we1,
    input  logic [$clog2(DEPTH)-1:0] wa1,
    input  logic [EW-1:0]            wd1,
    input  logic                     we2,
    input  logic [$clog2(DEPTH)-1:0] wa2,
    input  logic [EW-1:0]            wd2,
    input  logic [$clog2(DEPTH)-1:0] ra0,
    input  logic [$clog2(DEPTH)-1:0] ra1,
    input  logic [$clog2(DEPTH)-1:0] ra2,
    output logic [EW-1:0]            rd0,
    output logic [EW-1:0]            rd1,
    output logic [EW-1:0]            rd2
);

    logic [EW-1:0] mem [DEPTH];

    // Synchronous clear, otherwise up to two writes (addresses always differ).
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we1) mem[wa1] <= wd1;
            if (we2) mem[wa2] <= wd2;
        end
    end

    // Combinational read ports for head, head+1, head+2.
    always_comb begin
        rd0 = mem[ra0];
        rd1 = mem[ra1];
        rd2 = mem[ra2];
    end

endmodule

// File: rtl/issue_queue.sv
// Dual-issue instruction queue: buffers decoded instructions, presents the
// two oldest eligible entries, retires according to launch_flag.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = IQ_PC_W,
    parameter int unsigned DC_W  = IQ_DC_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid1,
    input  logic [PC_W-1:0]            in_pc1,
    input  logic [PC_W-1:0]            in_npc1,
    input  logic [DC_W-1:0]            in_decodeout1,
    input  logic                       in_valid2,
    input  logic [PC_W-1:0]            in_pc2,
    input  logic [PC_W-1:0]            in_npc2,
    input  logic [DC_W-1:0]            in_decodeout2,
    output logic                       in_ready,
    output logic [PC_W-1:0]            out1_pc,
    output logic [PC_W-1:0]            out1_npc,
    output logic [DC_W-1:0]            out1_decodeout,
    output logic                       receive_flag1,
    output logic [PC_W-1:0]            out2_pc,
    output logic [PC_W-1:0]            out2_npc,
    output logic [DC_W-1:0]            out2_decodeout,
    output logic                       receive_flag2,
    input  logic [3:0]                 launch_flag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 2 * PC_W + DC_W;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [AW-1:0] head, tail;
    logic [AW-1:0] head_p1, head_p2, tail_p1;
    skip_e         skip, skip_next;

    logic          l1, l2;
    logic          push1, push2;
    logic [1:0]    head_adv;
    logic [CW-1:0] push_n, ret_n;

    logic [EW-1:0] rd0, rd1, rd2, slot2;

    assign head_p1 = head + AW'(1);
    assign head_p2 = head + AW'(2);
    assign tail_p1 = tail + AW'(1);

    iq_store #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_store (
        .clk (clk),
        .clr (rst),
        .we1 (push1),
        .wa1 (tail),
        .wd1 ({in_pc1, in_npc1, in_decodeout1}),
        .we2 (push2),
        .wa2 (tail_p1),
        .wd2 ({in_pc2, in_npc2, in_decodeout2}),
        .ra0 (head),
        .ra1 (head_p1),
        .ra2 (head_p2),
        .rd0 (rd0),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    // Slot presentation from registered state only.
    always_comb begin
        in_ready       = (count <= READY_MAX);
        receive_flag1  = (count != '0);
        receive_flag2  = (skip == SK_NONE) && (count >= CW'(2));
        slot2          = (skip == SK_NONE) ? rd1 : rd2;
        {out1_pc, out1_npc, out1_decodeout} = rd0;
        {out2_pc, out2_npc, out2_decodeout} = slot2;
    end

    // Retire decision and skip next-state; push acceptance.
    always_comb begin
        l1        = (launch_flag[LF_S1E1] | launch_flag[LF_S1E2]) & receive_flag1;
        l2        = (launch_flag[LF_S2E1] | launch_flag[LF_S2E2]) & receive_flag2;
        skip_next = skip;
        head_adv  = 2'd0;
        ret_n     = '0;
        case (skip)
            SK_NONE: begin
                if (l1 && l2) begin
                    head_adv = 2'd2;
                    ret_n    = CW'(2);
                end else if (l1) begin
                    head_adv = 2'd1;
                    ret_n    = CW'(1);
                end else if (l2) begin
                    skip_next = SK_AHEAD;
                end
            end
            SK_AHEAD: begin
                // Head moves past the already-launched entry, retiring both.
                if (l1) begin
                    head_adv  = 2'd2;
                    ret_n     = CW'(2);
                    skip_next = SK_NONE;
                end
            end
            default: skip_next = SK_NONE;
        endcase
        push1  = in_valid1 & in_ready & ~flush & ~rst;
        push2  = push1 & in_valid2;
        push_n = CW'(push1) + CW'(push2);
    end

    // Pointer, count and skip registers; reset and flush clear everything.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            skip  <= SK_NONE;
        end else begin
            head  <= head + AW'(head_adv);
            tail  <= tail + AW'(push_n);
            count <= count + push_n - ret_n;
            skip  <= skip_next;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue (DEPTH=8).
module tb_issue_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned DC_W  = 67;

    logic            clk = 1'b0;
    logic            rst, flush;
    logic            in_valid1, in_valid2;
    logic [PC_W-1:0] in_pc1, in_npc1, in_pc2, in_npc2;
    logic [DC_W-1:0] in_decodeout1, in_decodeout2;
    logic            in_ready;
    logic [PC_W-1:0] out1_pc, out1_npc, out2_pc, out2_npc;
    logic [DC_W-1:0] out1_decodeout, out2_decodeout;
    logic            receive_flag1, receive_flag2;
    logic [3:0]      launch_flag;
    logic [3:0]      count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    issue_queue #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W),
        .DC_W  (DC_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid1      (in_valid1),
        .in_pc1         (in_pc1),
        .in_npc1        (in_npc1),
        .in_decodeout1  (in_decodeout1),
        .in_valid2      (in_valid2),
        .in_pc2         (in_pc2),
        .in_npc2        (in_npc2),
        .in_decodeout2  (in_decodeout2),
        .in_ready       (in_ready),
        .out1_pc        (out1_pc),
        .out1_npc       (out1_npc),
        .out1_decodeout (out1_decodeout),
        .receive_flag1  (receive_flag1),
        .out2_pc        (out2_pc),
        .out2_npc       (out2_npc),
        .out2_decodeout (out2_decodeout),
        .receive_flag2  (receive_flag2),
        .launch_flag    (launch_flag),
        .count          (count)
    );

    always #5 clk = ~clk;

    function automatic logic [DC_W-1:0] dc_of(input logic [PC_W-1:0] pc);
        return {3'b101, pc, ~pc};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid1 = 1'b0; in_valid2 = 1'b0; flush = 1'b0; launch_flag = 4'b0000;
        in_pc1 = '0; in_npc1 = '0; in_decodeout1 = '0;
        in_pc2 = '0; in_npc2 = '0; in_decodeout2 = '0;
    endtask

    task automatic drive_push(input logic two, input logic [PC_W-1:0] pa, input logic [PC_W-1:0] pb);
        in_valid1 = 1'b1; in_pc1 = pa; in_npc1 = pa + 4; in_decodeout1 = dc_of(pa);
        in_valid2 = two;  in_pc2 = pb; in_npc2 = pb + 4; in_decodeout2 = dc_of(pb);
    endtask

    task automatic check_slot1(input string tag, input logic [PC_W-1:0] pc);
        check({tag, ".s1pc"}, out1_pc, pc);
        check({tag, ".s1npc"}, out1_npc, pc + 4);
        check({tag, ".s1dc"}, out1_decodeout, dc_of(pc));
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // Reset / idle state
        check("rst.rf1", receive_flag1, 0);
        check("rst.rf2", receive_flag2, 0);
        check("rst.count", count, 0);
        check("rst.ready", in_ready, 1);
        check("rst.s1pc", out1_pc, 0);
        check("rst.s1dc", out1_decodeout, 0);
        check("rst.s2npc", out2_npc, 0);
        check("rst.s2dc", out2_decodeout, 0);

        // Pair push then dual launch
        drive_push(1, 32'h100, 32'h104);
        step();
        drive_idle();
        check_slot1("pair", 32'h100);
        check("pair.s2pc", out2_pc, 32'h104);
        check("pair.s2dc", out2_decodeout, dc_of(32'h104));
        check("pair.rf1", receive_flag1, 1);
        check("pair.rf2", receive_flag2, 1);
        check("pair.count", count, 2);
        launch_flag = 4'b1001;
        step();
        drive_idle();
        check("pair.drain", count, 0);
        check("pair.rf1z", receive_flag1, 0);

        // Skip-ahead: slot 2 launches first
        drive_push(1, 32'h200, 32'h204);
        step();
        drive_push(1, 32'h208, 32'h20C);
        step();
        drive_idle();
        check("skip.count4", count, 4);
        launch_flag = 4'b0010;
        step();
        drive_idle();
        check("skip.count", count, 4);
        check("skip.rf2", receive_flag2, 0);
        check("skip.rf1", receive_flag1, 1);
        check("skip.s1pc", out1_pc, 32'h200);
        launch_flag = 4'b1000;
        step();
        drive_idle();
        check("skip.retire", count, 2);
        check("skip.s1pc2", out1_pc, 32'h208);
        check("skip.s2pc", out2_pc, 32'h20C);
        check("skip.rf2b", receive_flag2, 1);
        launch_flag = 4'b1001;
        step();
        drive_idle();
        check("skip.drain", count, 0);

        // Launch bits on invalid slots are ignored
        launch_flag = 4'b1111;
        step();
        drive_idle();
        check("inv.empty", count, 0);
        drive_push(0, 32'h300, 32'h0);
        in_valid2 = 1'b0;
        step();
        drive_idle();
        check("inv.count1", count, 1);
        check("inv.rf2", receive_flag2, 0);
        launch_flag = 4'b0011;
        step();
        drive_idle();
        check("inv.s2ign", count, 1);
        check("inv.s1pc", out1_pc, 32'h300);
        launch_flag = 4'b0100;
        step();
        drive_idle();
        check("inv.drain", count, 0);

        // in_valid2 without in_valid1 is ignored
        in_valid2 = 1'b1; in_pc2 = 32'h350;
        step();
        drive_idle();
        check("v2only.count", count, 0);

        // Fill to 7, dropped push while not ready
        for (int k = 0; k < 3; k++) begin
            drive_push(1, 32'h400 + 32'(8 * k), 32'h404 + 32'(8 * k));
            step();
        end
        drive_idle();
        check("fill.count6", count, 6);
        check("fill.ready6", in_ready, 1);
        drive_push(0, 32'h418, 32'h0);
        step();
        drive_idle();
        check("fill.count7", count, 7);
        check("fill.ready7", in_ready, 0);
        drive_push(1, 32'hDEAD, 32'hBEEF);
        step();
        drive_idle();
        check("drop.count", count, 7);
        check_slot1("drop", 32'h400);
        launch_flag = 4'b1001;
        step();
        drive_idle();
        check("fill.count5", count, 5);
        check("fill.ready5", in_ready, 1);
        check("fill.s1pc", out1_pc, 32'h408);
        launch_flag = 4'b1001;
        step();
        launch_flag = 4'b1001;
        step();
        drive_idle();
        check("fill.last", out1_pc, 32'h418);
        launch_flag = 4'b1000;
        step();
        drive_idle();
        check("fill.drain", count, 0);

        // Streaming across pointer wrap: 20 entries, 2 in / 2 out per cycle
        drive_push(1, 32'h1000, 32'h1004);
        step();
        for (int k = 1; k < 10; k++) begin
            check("wrap.s1pc", out1_pc, 32'h1000 + 32'(8 * (k - 1)));
            check("wrap.s2pc", out2_pc, 32'h1004 + 32'(8 * (k - 1)));
            check("wrap.count", count, 2);
            drive_push(1, 32'h1000 + 32'(8 * k), 32'h1004 + 32'(8 * k));
            launch_flag = 4'b1001;
            step();
        end
        drive_idle();
        check_slot1("wrap.end", 32'h1048);
        launch_flag = 4'b0110;
        step();
        drive_idle();
        check("wrap.drain", count, 0);

        // Flush with simultaneous push and launch while skipped
        drive_push(1, 32'h600, 32'h604);
        step();
        drive_push(1, 32'h608, 32'h60C);
        step();
        drive_push(0, 32'h610, 32'h0);
        step();
        drive_idle();
        launch_flag = 4'b0010;
        step();
        drive_idle();
        check("fl.pre.count", count, 5);
        check("fl.pre.rf2", receive_flag2, 0);
        drive_push(1, 32'h680, 32'h684);
        launch_flag = 4'b1111;
        flush = 1'b1;
        step();
        drive_idle();
        check("fl.count", count, 0);
        check("fl.rf1", receive_flag1, 0);
        check("fl.rf2", receive_flag2, 0);
        check("fl.ready", in_ready, 1);
        drive_push(1, 32'h700, 32'h704);
        step();
        drive_idle();
        check("fl.post.count", count, 2);
        check("fl.post.rf2", receive_flag2, 1);
        check_slot1("fl.post", 32'h700);
        check("fl.post.s2pc", out2_pc, 32'h704);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
